// File: rtl/soc_input_pio_pkg.sv
// Shared register map and reset constants for the soc_input_pio block.
package soc_input_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEBOUNCE = 3'd5;
  localparam logic [2:0] ADDR_RAW      = 3'd6;

  localparam logic [31:0] FALL_EN_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/soc_input_debounce.sv
// One debounce channel: stable takes sync after it has differed for limit+1 cycles.
// With SOC_INPUT_PIO_DEBOUNCE_EN undefined the counter is removed and stable tracks sync.
module soc_input_debounce #(
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  parameter int   DB_W      = 20,
`endif
  parameter logic RESET_VAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sync,
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  input  logic [DB_W-1:0] limit,
`endif
  output logic            stable
);

`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] cnt;

  // >= so that lowering the limit mid-count releases the channel at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_VAL;
      cnt    <= '0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt >= limit) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable <= RESET_VAL;
    else          stable <= sync;
  end
`endif

endmodule

// File: rtl/soc_input_pio.sv
// Avalon-MM input PIO: synchroniser, per-channel debounce, edge select, W1C capture, masked irq.
// Define SOC_INPUT_PIO_DEBOUNCE_EN to build the debounce counters and DEBOUNCE register.
module soc_input_pio
  import soc_input_pio_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               DB_W         = 20,
  parameter logic [WIDTH-1:0] IN_RESET_VAL = {WIDTH{1'b1}},
  parameter int               DB_RESET_VAL = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || DB_W < 1 || DB_W > 32 || DB_RESET_VAL < 0) begin : g_bad_cfg
    $error("soc_input_pio: WIDTH and DB_W must be 1..32, DB_RESET_VAL non-negative");
  end

  logic [WIDTH-1:0] sync1, sync2, stable, stable_d;
  logic [WIDTH-1:0] rise_en, fall_en, irq_mask, edge_cap;
  logic [WIDTH-1:0] rise, fall, cap_clr, wdata;
  logic             wr;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign wr           = chipselect && !write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  logic [DB_W-1:0] db_limit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          db_limit <= DB_W'(DB_RESET_VAL);
    else if (wr && address == ADDR_DEBOUNCE) db_limit <= writedata[DB_W-1:0];
  end
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    soc_input_debounce #(
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
      .DB_W      (DB_W),
`endif
      .RESET_VAL (IN_RESET_VAL[g])
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .sync    (sync2[g]),
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
      .limit   (db_limit),
`endif
      .stable  (stable[g])
    );
  end

  assign rise    = stable & ~stable_d & rise_en;
  assign fall    = ~stable & stable_d & fall_en;
  assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;
  assign irq     = |(edge_cap & irq_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= IN_RESET_VAL;
      sync2    <= IN_RESET_VAL;
      stable_d <= IN_RESET_VAL;
      rise_en  <= '0;
      irq_mask <= '0;
      fall_en  <= FALL_EN_RESET[WIDTH-1:0];
      edge_cap <= '0;
    end else begin
      sync1    <= in_port;
      sync2    <= sync1;
      stable_d <= stable;
      if (wr && address == ADDR_RISE_EN)  rise_en  <= wdata;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_FALL_EN)  fall_en  <= wdata;
      // a new edge wins over a same-cycle clear so no event is dropped
      edge_cap <= (edge_cap & ~cap_clr) | rise | fall;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:     rd_next = 32'(stable);
      ADDR_RISE_EN:  rd_next = 32'(rise_en);
      ADDR_IRQ_MASK: rd_next = 32'(irq_mask);
      ADDR_EDGE_CAP: rd_next = 32'(edge_cap);
      ADDR_FALL_EN:  rd_next = 32'(fall_en);
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
      ADDR_DEBOUNCE: rd_next = 32'(db_limit);
`endif
      ADDR_RAW:      rd_next = 32'(sync2);
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

endmodule

// File: tb/tb_soc_input_pio.sv
// Self-checking bench for soc_input_pio: directed scenarios plus random traffic vs a reference model.
module tb_soc_input_pio;

  localparam int W = 4;
`ifdef SOC_INPUT_PIO_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '1;
  logic [31:0]   readdata;
  logic          irq;

  always #5 clk = ~clk;

  soc_input_pio #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an input bit becomes the stable state once it has been seen
  // at the synchroniser output with the new value for more than L consecutive samples.
  logic [W-1:0] m_s1, m_s2, m_stable, m_prev, m_rise, m_fall, m_mask, m_cap, rv;
  logic [W-1:0] t_nstable, t_edges;
  logic [31:0]  m_l, m_rd;
  int           run [W];
  int           eff_l;

  function automatic logic [31:0] reg_val(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_stable);
      3'd1: return 32'(m_rise);
      3'd2: return 32'(m_mask);
      3'd3: return 32'(m_cap);
      3'd4: return 32'(m_fall);
      3'd5: return DB ? m_l : 32'd0;
      3'd6: return 32'(m_s2);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_prev = '1;
      m_rise = '0; m_mask = '0; m_fall = '1; m_cap = '0;
      m_l = 32'd50000; m_rd = '0; rv = '1;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      m_rd = reg_val(address);
      eff_l = DB ? int'(m_l) : 0;
      // an edge is the stable value having just changed, filtered by direction enable
      t_edges = (m_stable ^ m_prev) & ((m_stable & m_rise) | (~m_stable & m_fall));
      t_nstable = m_stable;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == rv[i]) begin
          if (run[i] < 1000000) run[i]++;
        end else begin
          rv[i] = m_s2[i];
          run[i] = 1;
        end
        if (m_s2[i] != m_stable[i] && run[i] > eff_l) t_nstable[i] = m_s2[i];
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd1: m_rise = writedata[W-1:0];
          3'd2: m_mask = writedata[W-1:0];
          3'd3: m_cap  = m_cap & ~writedata[W-1:0];
          3'd4: m_fall = writedata[W-1:0];
          3'd5: if (DB) m_l = {12'd0, writedata[19:0]};
          default: ;
        endcase
      end
      m_cap    = m_cap | t_edges;
      m_prev   = m_stable;
      m_stable = t_nstable;
      m_s2     = m_s1;
      m_s1     = in_port;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("model_rdata", readdata, m_rd);
      chk("model_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end
  end

  // All tasks start and end at a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  logic [31:0] d;
  int          k;

  initial begin
    // reset state
    idle(2);
    #1;
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    bus_read(3'd0, d); chk("rst_data", d, 32'hF);
    bus_read(3'd3, d); chk("rst_cap", d, 32'h0);
    bus_read(3'd4, d); chk("rst_fall_en", d, 32'hF);
    bus_read(3'd5, d); chk("rst_debounce", d, DB ? 32'd50000 : 32'd0);
    chk("rst_irq_rel", 32'(irq), 32'd0);
    bus_write(3'd5, 32'd100);
    bus_read(3'd5, d); chk("debounce_wr", d, DB ? 32'd100 : 32'd0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, d); chk("addr7", d, 32'd0);

    // debounce: short pulse filtered, long pulse captured at T(4+L)
    bus_write(3'd5, 32'd3);
    bus_write(3'd4, 32'h1);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b0; idle(3); in_port[0] = 1'b1; idle(12);
    bus_read(3'd3, d); chk("short_pulse", d, DB ? 32'h0 : 32'h1);
    bus_write(3'd3, 32'h1);
    k = DB ? 7 : 4;
    in_port[0] = 1'b0;
    idle(k - 1); chk("irq_before_cap", 32'(irq), 32'd0);
    idle(1);     chk("irq_at_cap", 32'(irq), 32'd1);
    idle(10 - k);
    in_port[0] = 1'b1; idle(12);
    bus_read(3'd3, d); chk("no_rise_recap", d, 32'h1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d); chk("w1c_clear", d, 32'h0);
    chk("irq_cleared", 32'(irq), 32'd0);

    // both edges on bit1 with L=0
    bus_write(3'd5, 32'd0);
    bus_write(3'd1, 32'h2);
    bus_write(3'd4, 32'h2);
    bus_write(3'd2, 32'h0);
    in_port[1] = 1'b0; idle(6);
    bus_read(3'd3, d); chk("fall_bit1", d, 32'h2);
    bus_write(3'd3, 32'h2);
    in_port[1] = 1'b1; idle(6);
    bus_read(3'd3, d); chk("rise_bit1", d, 32'h2);
    bus_write(3'd3, 32'hF);

    // partial W1C leaves the other captured bit and its irq
    bus_write(3'd4, 32'h5);
    bus_write(3'd2, 32'h4);
    in_port = 4'b1010; idle(6);
    bus_read(3'd3, d); chk("cap_bits_0_2", d, 32'h5);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d); chk("partial_w1c", d, 32'h4);
    chk("irq_bit2_held", 32'(irq), 32'd1);
    in_port = 4'hF; idle(6);
    bus_write(3'd3, 32'hF);

    // new edge coinciding with W1C of the same bit: set wins
    bus_write(3'd4, 32'h1);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b0; idle(3);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, d); chk("set_beats_clear", d, 32'h1);
    in_port[0] = 1'b1; idle(6);
    bus_write(3'd3, 32'hF);

    // single-cycle pulse passes with L=0, captured at T4
    in_port[0] = 1'b0; idle(1); in_port[0] = 1'b1;
    idle(2); chk("pulse_irq_t3", 32'(irq), 32'd0);
    idle(1); chk("pulse_irq_t4", 32'(irq), 32'd1);
    bus_read(3'd3, d); chk("pulse_cap", d, 32'h1);

    // asynchronous reset mid-capture
    reset_n = 1'b0;
    #1;
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_rdata", readdata, 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    bus_read(3'd3, d); chk("post_rst_cap", d, 32'h0);
    bus_read(3'd2, d); chk("post_rst_mask", d, 32'h0);
    bus_read(3'd5, d); chk("post_rst_db", d, DB ? 32'd50000 : 32'd0);

    // random traffic, checked every cycle against the model
    bus_write(3'd5, 32'd2);
    bus_write(3'd2, 32'hF);
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = (address == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
